// File: rtl/ps2_keycode_rx_pkg.sv
// Shared keycode constants, receive-state encoding and frame parity helper
// for the PS/2 keypad receiver.
package ps2_keycode_rx_pkg;

  localparam logic [7:0] KP_INVALID      = 8'h00;
  localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
  localparam logic [7:0] KP_EXTENDED     = 8'hE0;

  localparam logic [7:0] KP_0     = 8'h70;
  localparam logic [7:0] KP_1     = 8'h69;
  localparam logic [7:0] KP_2     = 8'h72;
  localparam logic [7:0] KP_3     = 8'h7A;
  localparam logic [7:0] KP_4     = 8'h6B;
  localparam logic [7:0] KP_5     = 8'h73;
  localparam logic [7:0] KP_6     = 8'h74;
  localparam logic [7:0] KP_7     = 8'h6C;
  localparam logic [7:0] KP_8     = 8'h75;
  localparam logic [7:0] KP_9     = 8'h7D;
  localparam logic [7:0] KP_STAR  = 8'h7C;
  localparam logic [7:0] KP_MINUS = 8'h7B;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA    = 3'd1,
    ST_PARITY  = 3'd2,
    ST_STOP    = 3'd3,
    ST_DELIVER = 3'd4
  } rx_state_t;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keycode_rx_sync.sv
// Two-flop synchronizer for a raw PS/2 line with falling-edge detection
// on the synchronized value.
module ps2_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic sync_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta      <= 1'b1;
      sync_q    <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      meta      <= async_in;
      sync_q    <= meta;
      sync_prev <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall     = sync_prev & ~sync_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard frame receiver producing a registered keycode stream with
// break-code handling and a timed hold of released-key codes.
module ps2_keycode_rx
  import ps2_keycode_rx_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES      = 16'd50000,
  parameter logic [7:0]  RELEASE_HOLD_CYCLES = 8'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic       key_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic [3:0] debug_state_out
);

  logic ps2_fall;
  logic clk_s;
  logic data_s;

  ps2_sync u_sync_clk (
    .clk      (clk),
    .reset    (reset),
    .async_in (ps2_clk),
    .sync_out (clk_s),
    .fall     (ps2_fall)
  );

  ps2_sync u_sync_data (
    .clk      (clk),
    .reset    (reset),
    .async_in (ps2_data),
    .sync_out (data_s),
    .fall     ()
  );

  rx_state_t   state, state_next;
  logic [2:0]  bit_count;
  logic [7:0]  shift;
  logic        parity_bit;
  logic [15:0] tmo_cnt;
  logic        timeout;
  logic        pe_next, fe_next;
  logic        break_pending;
  logic [7:0]  hold_cnt;
  logic        clk_s_unused;

  assign clk_s_unused = clk_s;
  assign timeout = (state != ST_IDLE) && !ps2_fall && (tmo_cnt == TIMEOUT_CYCLES - 16'd1);
  assign debug_state_out = {1'b0, state};

  always_comb begin
    state_next = state;
    pe_next    = 1'b0;
    fe_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ps2_fall) begin
          if (data_s) fe_next = 1'b1;
          else        state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ps2_fall) begin
          if (bit_count == 3'd7) state_next = ST_PARITY;
        end else if (timeout) begin
          fe_next    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_PARITY: begin
        if (ps2_fall) begin
          state_next = ST_STOP;
        end else if (timeout) begin
          fe_next    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_STOP: begin
        // A bad parity masks a simultaneous bad stop bit.
        if (ps2_fall) begin
          if (!frame_parity_ok(shift, parity_bit)) begin
            pe_next    = 1'b1;
            state_next = ST_IDLE;
          end else if (!data_s) begin
            fe_next    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DELIVER;
          end
        end else if (timeout) begin
          fe_next    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DELIVER: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_count    <= '0;
      shift        <= '0;
      parity_bit   <= 1'b0;
      tmo_cnt      <= '0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state        <= state_next;
      parity_error <= pe_next;
      frame_error  <= fe_next;
      if (ps2_fall) begin
        case (state)
          ST_IDLE:   bit_count <= '0;
          ST_DATA: begin
            shift     <= {data_s, shift[7:1]};
            bit_count <= bit_count + 3'd1;
          end
          ST_PARITY: parity_bit <= data_s;
          default:   ;
        endcase
      end
      if (state == ST_IDLE || ps2_fall) tmo_cnt <= '0;
      else                              tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // The extended prefix is swallowed without disturbing a running hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key           <= KP_INVALID;
      key_valid     <= 1'b0;
      break_pending <= 1'b0;
      hold_cnt      <= '0;
    end else begin
      key_valid <= 1'b0;
      if (state == ST_DELIVER && shift != KP_EXTENDED) begin
        key       <= shift;
        key_valid <= 1'b1;
        if (shift == KP_KEY_RELEASED) begin
          break_pending <= 1'b1;
          hold_cnt      <= '0;
        end else if (break_pending) begin
          break_pending <= 1'b0;
          hold_cnt      <= RELEASE_HOLD_CYCLES;
        end else begin
          hold_cnt <= '0;
        end
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 8'd1;
        if (hold_cnt == 8'd1) key <= KP_INVALID;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Randomized self-checking bench for ps2_keycode_rx using a time-stamped
// event model of the keycode stream.
module tb_ps2_keycode_rx;
  import ps2_keycode_rx_pkg::*;

  localparam int TMO = 50000;
  localparam int RHC = 16;
  localparam int EV_DELIVER = 0;
  localparam int EV_PERR    = 1;
  localparam int EV_FERR    = 2;
  localparam int EV_STATE   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key;
  logic       key_valid, parity_error, frame_error;
  logic [3:0] debug_state_out;

  ps2_keycode_rx #(.TIMEOUT_CYCLES(16'd50000), .RELEASE_HOLD_CYCLES(8'd16)) dut (
    .clk             (clk),
    .reset           (reset),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .key             (key),
    .key_valid       (key_valid),
    .parity_error    (parity_error),
    .frame_error     (frame_error),
    .debug_state_out (debug_state_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         c;
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t        evq[$];
  ev_t        e;
  logic [7:0] m_key = KP_INVALID;
  bit         m_brk = 1'b0;
  int         m_inv_at = -1;
  bit         chk_en = 1'b0;
  bit         tmo_on = 1'b0;
  int         tmo_lo, tmo_hi, tmo_pulses;
  logic       ekv, epe, efe;
  int         kv_count = 0, pe_count = 0, fe_count = 0, kv_cyc = 0;

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      ekv = 1'b0; epe = 1'b0; efe = 1'b0;
      while (evq.size() > 0 && evq[0].c <= cyc) begin
        e = evq.pop_front();
        case (e.kind)
          EV_DELIVER: begin
            if (e.val != KP_EXTENDED) begin
              ekv   = 1'b1;
              m_key = e.val;
              if (e.val == KP_KEY_RELEASED) begin
                m_brk = 1'b1; m_inv_at = -1;
              end else if (m_brk) begin
                m_brk = 1'b0; m_inv_at = e.c + RHC;
              end else begin
                m_inv_at = -1;
              end
            end
          end
          EV_PERR:  epe = 1'b1;
          EV_FERR:  efe = 1'b1;
          EV_STATE: check("debug_state", {28'd0, debug_state_out}, {24'd0, e.val});
          default: ;
        endcase
      end
      if (m_inv_at >= 0 && cyc >= m_inv_at) begin
        m_key = KP_INVALID; m_inv_at = -1;
      end
      check("key", {24'd0, key}, {24'd0, m_key});
      check("key_valid", {31'd0, key_valid}, {31'd0, ekv});
      check("parity_error", {31'd0, parity_error}, {31'd0, epe});
      if (tmo_on && cyc >= tmo_lo && cyc <= tmo_hi) begin
        if (frame_error) tmo_pulses++;
        if (cyc == tmo_hi) begin
          check("timeout_fe_pulses", tmo_pulses, 1);
          tmo_on = 1'b0;
        end
      end else begin
        check("frame_error", {31'd0, frame_error}, {31'd0, efe});
      end
      if (key_valid) begin kv_count++; kv_cyc = cyc; end
      if (parity_error) pe_count++;
      if (frame_error) fe_count++;
    end
  end

  task automatic edge_down(input logic d, input int hp, output int p);
    ps2_data = d;
    repeat (hp) @(posedge clk);
    #1 ps2_clk = 1'b0;
    p = cyc;
  endtask

  task automatic edge_up(input int hp);
    repeat (hp) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(posedge clk);
    #1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad parity and bad stop
  task automatic send_frame(input logic [7:0] b, input int kind, input int hp, output int p);
    logic [10:0] f;
    logic        par;
    par = ~^b;
    if (kind == 1 || kind == 3) par = ~par;
    f = {(kind == 2 || kind == 3) ? 1'b0 : 1'b1, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      edge_down(f[i], hp, p);
      if (i == 10) begin
        if (kind == 1 || kind == 3) begin
          evq.push_back('{p + 3, EV_STATE, 8'd0});
          evq.push_back('{p + 3, EV_PERR, 8'd0});
        end else if (kind == 2) begin
          evq.push_back('{p + 3, EV_STATE, 8'd0});
          evq.push_back('{p + 3, EV_FERR, 8'd0});
        end else begin
          evq.push_back('{p + 3, EV_STATE, 8'd4});
          evq.push_back('{p + 4, EV_DELIVER, b});
        end
      end
      edge_up(hp);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int n, input int hp, output int p);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      edge_down(f[i], hp, p);
      edge_up(hp);
    end
  endtask

  task automatic send_bad_start(input int hp);
    int p;
    edge_down(1'b1, hp, p);
    evq.push_back('{p + 3, EV_STATE, 8'd0});
    evq.push_back('{p + 3, EV_FERR, 8'd0});
    edge_up(hp);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int p, k0, pe0, fe0, hp, r, kind;
    logic [7:0] b, last_b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_key", {24'd0, key}, {24'd0, KP_INVALID});
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_parity_error", {31'd0, parity_error}, 32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    check("rst_state", {28'd0, debug_state_out}, 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    send_frame(8'h69, 0, 4, p);
    check("lit_69_dut", {24'd0, key}, 32'h69);
    check("lit_69_model", {24'd0, m_key}, 32'h69);
    check("lit_69_latency", kv_cyc - p, 4);

    send_frame(8'hF0, 0, 3, p);
    check("lit_F0_dut", {24'd0, key}, 32'hF0);
    send_frame(8'h69, 0, 3, p);
    k0 = kv_count;
    wait_until(p + 4 + 8);
    check("lit_break_69_dut", {24'd0, key}, 32'h69);
    wait_until(p + 4 + RHC + 3);
    check("lit_released_invalid_dut", {24'd0, key}, {24'd0, KP_INVALID});
    check("lit_released_invalid_model", {24'd0, m_key}, {24'd0, KP_INVALID});
    check("lit_released_no_kv", kv_count - k0, 0);

    k0 = kv_count; pe0 = pe_count;
    send_frame(8'h70, 1, 4, p);
    check("lit_perr_pulses", pe_count - pe0, 1);
    check("lit_perr_no_kv", kv_count - k0, 0);
    check("lit_perr_key", {24'd0, key}, {24'd0, KP_INVALID});

    fe0 = fe_count;
    send_bad_start(3);
    check("lit_bad_start_fe", fe_count - fe0, 1);

    send_partial(8'h55, 5, 4, p);
    tmo_lo = p + 3 + TMO - 4; tmo_hi = p + 3 + TMO + 4;
    tmo_pulses = 0; tmo_on = 1'b1;
    wait_until(tmo_hi + 5);
    check("lit_timeout_seen", {31'd0, tmo_on}, 32'd0);
    send_frame(8'h7C, 0, 5, p);
    check("lit_7C_after_timeout", {24'd0, key}, 32'h7C);

    k0 = kv_count;
    send_frame(8'hE0, 0, 3, p);
    send_frame(8'h7C, 0, 3, p);
    check("lit_E0_7C_kv", kv_count - k0, 1);
    check("lit_E0_7C_key", {24'd0, key}, 32'h7C);

    send_partial(8'h11, 5, 4, p);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_key", {24'd0, key}, {24'd0, KP_INVALID});
    check("mid_rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_parity_error", {31'd0, parity_error}, 32'd0);
    check("mid_rst_frame_error", {31'd0, frame_error}, 32'd0);
    check("mid_rst_state", {28'd0, debug_state_out}, 32'd0);
    evq.delete();
    m_key = KP_INVALID; m_brk = 1'b0; m_inv_at = -1; tmo_on = 1'b0;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8'h7B, 0, 4, p);
    check("lit_7B_after_reset", {24'd0, key}, 32'h7B);

    last_b = 8'h7B;
    for (int n = 0; n < 120; n++) begin
      hp = $urandom_range(2, 7);
      r  = $urandom_range(0, 9);
      if (r == 0)      b = KP_KEY_RELEASED;
      else if (r == 1) b = KP_EXTENDED;
      else if (r == 2) b = last_b;
      else             b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 99);
      if (r < 4) begin
        send_bad_start(hp);
      end else begin
        if (r < 12)      kind = 1;
        else if (r < 18) kind = 2;
        else if (r < 22) kind = 3;
        else             kind = 0;
        send_frame(b, kind, hp, p);
        last_b = b;
      end
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #1;
    end
    wait_until(cyc + RHC + 8);
    check("events_drained", evq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
